ssd_uart_dump: RTL and testbench
================================

Name: ssd_uart_dump

Overview:
Reader end of the SSD results BRAM inside stereo_match. It is the block that drives `external_ssd_addr` and consumes `ssd_dout`. On a start pulse (top-level `get_output`) it walks every result address, fetches each 8-bit disparity, and streams the frame out of `uart_txd` as 8N1 serial. Each frame is prefixed by a 2-byte sync header. It sits in top_level between stereo_match and the `uart_txd` pin.

Parameters:
DEPTH, 12800, number of result entries read per frame (addresses 0..DEPTH-1)
CLKS_PER_BIT, 868, clk_in cycles per UART bit (100 MHz / 115200)
READ_LATENCY, 2, cycles from addr_out/rd_en_out valid to data_in valid (BRAM with output register)
SYNC0, 8'hA5, first header byte
SYNC1, 8'h5A, second header byte

Ports:
clk_in  input  1  system clock; the only clock
rst_in  input  1  reset, synchronous, active-high
start_in  input  1  one-cycle request to dump one frame; ignored while busy_out=1
addr_out  output  $clog2(DEPTH)  results BRAM read address
rd_en_out  output  1  read enable to results BRAM (drives stereo_match `reading`)
data_in  input  8  results BRAM read data, valid READ_LATENCY cycles after rd_en_out
busy_out  output  1  high from the cycle after an accepted start until the cycle done_out pulses
done_out  output  1  one-cycle pulse after the last stop bit of the frame completes
uart_txd  output  1  serial output; idle high

Behaviour:
- Reset values: uart_txd=1, busy_out=0, done_out=0, rd_en_out=0, addr_out=0. All counters and state are cleared. Reset applied mid-frame aborts the frame: uart_txd is high on the next cycle, no done_out pulse is produced, and an in-flight read is discarded.
- FSM states: IDLE -> HDR0 -> HDR1 -> DATA -> FINISH -> IDLE.
- IDLE -> HDR0 when start_in=1. A start_in that arrives in any other state is dropped and is not queued.
- Byte framing:
  - one start bit (0), then 8 data bits LSB-first, then one stop bit (1);
  - each bit lasts exactly CLKS_PER_BIT cycles, so one byte takes 10*CLKS_PER_BIT cycles;
  - the start bit of the next byte begins on the cycle immediately after the previous stop bit ends (no inter-byte gap).
- Frame timing: start_in accepted at cycle 0 -> the SYNC0 start bit is on uart_txd from cycle 1. Byte n (n=0 SYNC0, n=1 SYNC1, n>=2 is data address n-2) starts at cycle 1 + n*10*CLKS_PER_BIT.
- Prefetch:
  - the read for address k is issued (rd_en_out=1 for exactly one cycle, addr_out=k) on the first cycle of the start bit of byte k+1, i.e. the byte preceding its own;
  - data_in is captured into a holding register exactly READ_LATENCY cycles later;
  - addr_out holds its value until the next read is issued;
  - READ_LATENCY must be < 10*CLKS_PER_BIT, so the holding register is always valid before it is loaded into the shifter.
- Shift register loads on the cycle the start bit begins. Header bytes come from parameters; data bytes come from the holding register.
- After the stop bit of the data byte for address DEPTH-1:
  - FINISH lasts one cycle with done_out=1;
  - busy_out drops in that same cycle;
  - the FSM returns to IDLE.
- A start_in arriving in the same cycle as done_out is ignored. A start_in one cycle later is accepted.
- Total frame length: (DEPTH+2)*10*CLKS_PER_BIT cycles. done_out is at cycle 1 + (DEPTH+2)*10*CLKS_PER_BIT.
- Counter widths:
  - bit-timer: $clog2(CLKS_PER_BIT) bits;
  - bit index: 0..9;
  - address counter: $clog2(DEPTH) bits, with no wrap past DEPTH-1.
- DEPTH=1 is legal: header plus one data byte.

Test Plan:
- DEPTH=4, CLKS_PER_BIT=4, READ_LATENCY=2, BRAM model returns {10,20,30,40}; pulse start_in at cycle 0 -> uart_txd decodes to A5 5A 0A 14 1E 28. Start bits at cycles 1, 41, 81, 121, 161, 201. done_out=1 only at cycle 241. busy_out is high over cycles 1..240.
- Same config: check rd_en_out pulses exactly 4 times, at cycles 41, 81, 121, 161, with addr_out = 0, 1, 2, 3 respectively. No rd_en_out outside those cycles.
- Data byte 8'hFF and byte 8'h00 -> bit-accurate serial waveform: LSB first, stop bit high, no glitch between back-to-back bytes.
- start_in pulsed again at cycles 50 and 241 -> both ignored; a pulse at cycle 242 starts a new frame with its SYNC0 start bit at cycle 243.
- rst_in asserted at cycle 100 for 1 cycle -> uart_txd=1 from cycle 101; busy_out=0, no done_out. A start at cycle 110 produces a complete, correct frame from address 0.
- DEPTH=1, CLKS_PER_BIT=3, READ_LATENCY=1 -> frame A5 5A xx, done_out at cycle 1 + 3*30 = 91.

Source files
------------

// File: rtl/ssd_uart_dump.sv
// Results-BRAM reader: walks addresses 0..DEPTH-1, prefetching one byte ahead,
// and streams a 2-byte sync header plus the disparities out as back-to-back 8N1.
module ssd_uart_dump #(
    parameter int         DEPTH        = 12800,
    parameter int         CLKS_PER_BIT = 868,
    parameter int         READ_LATENCY = 2,
    parameter logic [7:0] SYNC0        = 8'hA5,
    parameter logic [7:0] SYNC1        = 8'h5A,
    localparam int        AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int        TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    output logic [AW-1:0] addr_out,
    output logic          rd_en_out,
    input  logic [7:0]    data_in,
    output logic          busy_out,
    output logic          done_out,
    output logic          uart_txd
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, FINISH} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    state_t                  state, state_nxt;
    logic [TW-1:0]           bit_tmr;
    logic [3:0]              bit_idx;
    logic [7:0]              shift_q;
    logic [7:0]              hold;
    logic [AW-1:0]           tx_addr;
    logic [READ_LATENCY-1:0] vld_p;

    logic          bit_tick, byte_end;
    logic          load, issue, tx_addr_clr, tx_addr_inc;
    logic [7:0]    load_byte, hold_fwd;
    logic [AW-1:0] issue_addr;

    assign bit_tick = (bit_tmr == BIT_LAST);
    assign byte_end = bit_tick && (bit_idx == 4'd9);
    // A capture landing on the same edge as the shifter load is forwarded directly.
    assign hold_fwd = vld_p[READ_LATENCY-1] ? data_in : hold;

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        load_byte   = SYNC0;
        issue       = 1'b0;
        issue_addr  = addr_out;
        tx_addr_clr = 1'b0;
        tx_addr_inc = 1'b0;
        busy_out    = 1'b0;
        done_out    = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = HDR0;
                    load      = 1'b1;
                    load_byte = SYNC0;
                end
            end
            HDR0: begin
                busy_out = 1'b1;
                if (byte_end) begin
                    state_nxt  = HDR1;
                    load       = 1'b1;
                    load_byte  = SYNC1;
                    issue      = 1'b1;
                    issue_addr = '0;
                end
            end
            HDR1: begin
                busy_out = 1'b1;
                if (byte_end) begin
                    state_nxt   = DATA;
                    load        = 1'b1;
                    load_byte   = hold_fwd;
                    tx_addr_clr = 1'b1;
                    issue       = (DEPTH > 1);
                    issue_addr  = AW'(1);
                end
            end
            DATA: begin
                busy_out = 1'b1;
                if (byte_end) begin
                    if (tx_addr == LAST_ADDR) begin
                        state_nxt = FINISH;
                    end else begin
                        load        = 1'b1;
                        load_byte   = hold_fwd;
                        tx_addr_inc = 1'b1;
                        // addr_out already points one past tx_addr; stop at the last entry
                        issue       = (addr_out != LAST_ADDR);
                        issue_addr  = addr_out + AW'(1);
                    end
                end
            end
            FINISH: begin
                done_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            uart_txd  <= 1'b1;
            bit_tmr   <= '0;
            bit_idx   <= '0;
            tx_addr   <= '0;
            addr_out  <= '0;
            rd_en_out <= 1'b0;
            vld_p     <= '0;
        end else begin
            rd_en_out <= issue;
            if (issue) addr_out <= issue_addr;
            vld_p[0] <= rd_en_out;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
            if (tx_addr_clr)      tx_addr <= '0;
            else if (tx_addr_inc) tx_addr <= tx_addr + AW'(1);
            if (load) begin
                uart_txd <= 1'b0;
                bit_tmr  <= '0;
                bit_idx  <= '0;
            end else if (busy_out) begin
                if (bit_tick) begin
                    bit_tmr <= '0;
                    if (bit_idx == 4'd9) begin
                        bit_idx <= '0;
                    end else begin
                        bit_idx  <= bit_idx + 4'd1;
                        uart_txd <= (bit_idx == 4'd8) ? 1'b1 : shift_q[0];
                    end
                end else begin
                    bit_tmr <= bit_tmr + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (load)
            shift_q <= load_byte;
        else if (busy_out && bit_tick && bit_idx < 4'd8)
            shift_q <= {1'b0, shift_q[7:1]};
        if (vld_p[READ_LATENCY-1]) hold <= data_in;
    end

endmodule

// File: tb/tb_ssd_uart_dump.sv
// Bench for ssd_uart_dump: a DEPTH=4 instance checked through byte/read/done
// scoreboards, and a DEPTH=1 instance checked cycle by cycle.
module tb_ssd_uart_dump;
    localparam int CA = 4;
    localparam int DA = 4;
    localparam int CB = 3;

    typedef struct { logic [7:0] data; int start; } byte_exp_t;
    typedef struct { int cyc; int addr; } rd_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic       rst_a = 1'b1, start_a = 1'b0;
    logic       rd_en_a, busy_a, done_a, txd_a;
    logic [1:0] addr_a;
    logic [7:0] data_a;
    logic       rst_b = 1'b1, start_b = 1'b0;
    logic       rd_en_b, busy_b, done_b, txd_b;
    logic [0:0] addr_b;
    logic [7:0] data_b;

    logic [7:0] mem_a [4];
    logic [7:0] mem_b;
    logic [7:0] d1_a, d2_a, d1_b;
    logic       r1_a = 1'b0, r2_a = 1'b0, r1_b = 1'b0;

    // BRAM models: data is only meaningful exactly READ_LATENCY cycles after rd_en
    always @(posedge clk) begin
        r1_a <= rd_en_a;
        r2_a <= r1_a;
        d1_a <= mem_a[addr_a];
        d2_a <= d1_a;
        r1_b <= rd_en_b;
        d1_b <= mem_b;
    end
    assign data_a = r2_a ? d2_a : 8'hEE;
    assign data_b = r1_b ? d1_b : 8'hEE;

    ssd_uart_dump #(.DEPTH(DA), .CLKS_PER_BIT(CA), .READ_LATENCY(2)) dut_a (
        .clk_in(clk), .rst_in(rst_a), .start_in(start_a), .addr_out(addr_a),
        .rd_en_out(rd_en_a), .data_in(data_a), .busy_out(busy_a),
        .done_out(done_a), .uart_txd(txd_a)
    );

    ssd_uart_dump #(.DEPTH(1), .CLKS_PER_BIT(CB), .READ_LATENCY(1)) dut_b (
        .clk_in(clk), .rst_in(rst_b), .start_in(start_b), .addr_out(addr_b),
        .rd_en_out(rd_en_b), .data_in(data_b), .busy_out(busy_b),
        .done_out(done_b), .uart_txd(txd_b)
    );

    byte_exp_t exp_q[$];
    rd_exp_t   rd_q[$];
    int        done_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input int c, input int nbytes);
        byte_exp_t b;
        rd_exp_t   r;
        for (int n = 0; n < nbytes; n++) begin
            b.start = c + 1 + n * 10 * CA;
            if (n == 0)      b.data = 8'hA5;
            else if (n == 1) b.data = 8'h5A;
            else             b.data = mem_a[n-2];
            exp_q.push_back(b);
        end
        for (int k = 0; k < nbytes - 1 && k < DA; k++) begin
            r.cyc  = c + 1 + (k + 1) * 10 * CA;
            r.addr = k;
            rd_q.push_back(r);
        end
        if (nbytes == DA + 2) done_q.push_back(c + 1 + (DA + 2) * 10 * CA);
    endtask

    // UART decoder for instance A: pops the expected byte when a start bit appears
    bit        rx_act = 1'b0;
    int        rx_start;
    int        rel;
    logic [9:0] bitv;
    bit        glitch;
    byte_exp_t cur;
    always @(negedge clk) begin
        if (rst_a) begin
            rx_act = 1'b0;
            exp_q.delete();
        end else if (rx_act) begin
            rel = cyc - rx_start;
            if (rel % CA == 0) bitv[rel / CA] = txd_a;
            else if (txd_a !== bitv[rel / CA]) glitch = 1'b1;
            if (rel == 10 * CA - 1) begin
                rx_act = 1'b0;
                chk("byte_data", bitv[8:1], cur.data);
                chk("stop_bit", bitv[9], 1'b1);
                chk("bit_glitch", glitch, 1'b0);
            end
        end else if (txd_a === 1'b0) begin
            rx_act   = 1'b1;
            rx_start = cyc;
            glitch   = 1'b0;
            bitv     = '1;
            bitv[0]  = 1'b0;
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else begin
                cur.data  = 8'h00;
                cur.start = -1;
            end
            chk("byte_start_cycle", cyc, cur.start);
        end
    end

    rd_exp_t re;
    int      de;
    always @(negedge clk) begin
        if (!rst_a && rd_en_a === 1'b1) begin
            if (rd_q.size() > 0) re = rd_q.pop_front();
            else begin
                re.cyc  = -1;
                re.addr = -1;
            end
            chk("rd_en_cycle", cyc, re.cyc);
            chk("rd_addr", addr_a, re.addr);
        end
        if (!rst_a && done_a === 1'b1) begin
            de = (done_q.size() > 0) ? done_q.pop_front() : -1;
            chk("done_cycle", cyc, de);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, c2, c3, cb;
        logic [7:0] bytes_b [3];
        int n, p, bi;
        logic exp_tx;

        mem_a[0] = 8'd10; mem_a[1] = 8'd20; mem_a[2] = 8'd30; mem_a[3] = 8'd40;
        mem_b = 8'h3C;

        goto(3);
        @(negedge clk);
        chk("rst_txd_a", txd_a, 1'b1);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_done_a", done_a, 1'b0);
        chk("rst_rd_en_a", rd_en_a, 1'b0);
        chk("rst_addr_a", addr_a, 2'd0);
        chk("rst_txd_b", txd_b, 1'b1);
        chk("rst_busy_b", busy_b, 1'b0);
        goto(4);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Frame 1: data 10,20,30,40 with stray starts while busy and on done
        c0 = 10;
        goto(c0);
        push_frame(c0, DA + 2);
        start_a = 1'b1;
        @(negedge clk);
        chk("f1_busy_rel0", busy_a, 1'b0);
        goto(c0 + 1);
        start_a = 1'b0;
        @(negedge clk);
        chk("f1_busy_rel1", busy_a, 1'b1);
        chk("f1_txd_rel1", txd_a, 1'b0);
        goto(c0 + 50);
        start_a = 1'b1;
        goto(c0 + 51);
        start_a = 1'b0;
        goto(c0 + 240);
        @(negedge clk);
        chk("f1_busy_rel240", busy_a, 1'b1);

        // Frame 2 (FF/00 back to back) requested on the done cycle and the one after
        goto(c0 + 241);
        mem_a[0] = 8'hFF; mem_a[1] = 8'h00; mem_a[2] = 8'hFF; mem_a[3] = 8'h81;
        c1 = c0 + 242;
        push_frame(c1, DA + 2);
        start_a = 1'b1;
        @(negedge clk);
        chk("f1_busy_rel241", busy_a, 1'b0);
        chk("f1_done_rel241", done_a, 1'b1);
        goto(c1);
        @(negedge clk);
        chk("f2_busy_rel242", busy_a, 1'b0);
        goto(c1 + 1);
        start_a = 1'b0;
        @(negedge clk);
        chk("f2_txd_rel243", txd_a, 1'b0);
        chk("f2_busy_rel243", busy_a, 1'b1);

        // Frame 3 aborted by reset, then frame 4 from address 0
        c2 = c1 + 245;
        goto(c2);
        push_frame(c2, 3);
        start_a = 1'b1;
        goto(c2 + 1);
        start_a = 1'b0;
        goto(c2 + 100);
        rst_a = 1'b1;
        goto(c2 + 101);
        rst_a = 1'b0;
        @(negedge clk);
        chk("abort_txd", txd_a, 1'b1);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_done", done_a, 1'b0);
        chk("abort_rd_en", rd_en_a, 1'b0);
        chk("abort_addr", addr_a, 2'd0);
        goto(c2 + 109);
        @(negedge clk);
        chk("abort_txd_idle", txd_a, 1'b1);
        chk("abort_rd_q_empty", rd_q.size(), 0);
        chk("abort_done_q_empty", done_q.size(), 0);
        mem_a[0] = 8'h01; mem_a[1] = 8'h80; mem_a[2] = 8'h7E; mem_a[3] = 8'hAA;
        c3 = c2 + 110;
        goto(c3);
        push_frame(c3, DA + 2);
        start_a = 1'b1;
        goto(c3 + 1);
        start_a = 1'b0;
        goto(c3 + 245);
        @(negedge clk);
        chk("end_exp_q_empty", exp_q.size(), 0);
        chk("end_rd_q_empty", rd_q.size(), 0);
        chk("end_done_q_empty", done_q.size(), 0);
        chk("end_busy_a", busy_a, 1'b0);
        chk("end_txd_a", txd_a, 1'b1);

        // DEPTH=1 instance: full per-cycle waveform of A5 5A 3C
        bytes_b[0] = 8'hA5; bytes_b[1] = 8'h5A; bytes_b[2] = mem_b;
        cb = c3 + 250;
        goto(cb);
        start_b = 1'b1;
        for (int r = 0; r < 96; r++) begin
            goto(cb + r);
            if (r == 1) start_b = 1'b0;
            @(negedge clk);
            exp_tx = 1'b1;
            if (r >= 1 && r <= 90) begin
                n  = (r - 1) / 30;
                p  = (r - 1) % 30;
                bi = p / CB;
                if (bi == 0)      exp_tx = 1'b0;
                else if (bi == 9) exp_tx = 1'b1;
                else              exp_tx = bytes_b[n][bi-1];
            end
            chk("b_txd", txd_b, exp_tx);
            chk("b_busy", busy_b, (r >= 1 && r <= 90));
            chk("b_done", done_b, (r == 91));
            chk("b_rd_en", rd_en_b, (r == 31));
        end
        chk("b_addr", addr_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
